exynos4412_supervisor: RTL and testbench

//  Drives the enable input of the Exynos4412 power sequencer: holds CPU off after power-up, then enables it.

---
 rtl/exynos4412_supervisor.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_exynos4412_supervisor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exynos4412_supervisor.sv
// ---------------------------------------------------------------------------
// exynos4412_supervisor
//
// Supervises the enable input of the Exynos4412 power sequencer. After
// power-up it holds the CPU off for a settling period and then enables it.
// While the CPU runs, the supervisor watches the CPU heartbeat GPIO and the
// shutdown-request GPIO. It drops enable on a clean shutdown request, on
// loss of board power, or on a watchdog/boot-grace fault. After a fault it
// restarts automatically. Once MAX_RESTARTS consecutive faults have been
// restarted, the next fault locks the CPU out until power_good cycles.
//
// All timing is counted in ticks. A free-running sysclk prescaler produces
// one tick every TICK_DIV cycles (100us with the default parameters).
//
// Ports
//   sysclk           in   1  system clock
//   reset            in   1  asynchronous, active-high reset
//   power_good       in   1  board rails good (asynchronous, synchronised here)
//   cpu_heartbeat    in   1  CPU GPIO that toggles while the CPU is alive (async)
//   cpu_shutdown_req in   1  CPU GPIO, high = request power-off (async)
//   enable           out  1  sequencer enable, registered
//   fault            out  1  set by a watchdog/grace fault, cleared on entry to RUNNING
//   lockout          out  1  high while in LOCKOUT, registered
//   restart_count    out  2  consecutive fault restarts (saturates at 3)
//   state            out  3  current FSM state, for debug
// ---------------------------------------------------------------------------
module exynos4412_supervisor #(
    parameter int unsigned TICK_DIV         = 500,
    parameter int unsigned TIMER_W          = 20,
    parameter int unsigned STARTUP_TICKS    = 100,
    parameter int unsigned BOOT_GRACE_TICKS = 300000,
    parameter int unsigned HB_TIMEOUT_TICKS = 10000,
    parameter int unsigned OFF_TICKS        = 500,
    parameter int unsigned DEBOUNCE_TICKS   = 10,   // must be at least 1
    parameter int unsigned STABLE_TICKS     = 600000,
    parameter int unsigned MAX_RESTARTS     = 3     // 1..3
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       power_good,
    input  logic       cpu_heartbeat,
    input  logic       cpu_shutdown_req,
    output logic       enable,
    output logic       fault,
    output logic       lockout,
    output logic [1:0] restart_count,
    output logic [2:0] state
);

    // -----------------------------------------------------------------------
    // State encoding (codes 6 and 7 are illegal and fall back to STARTUP)
    // -----------------------------------------------------------------------
    localparam logic [2:0] S_STARTUP  = 3'd0;
    localparam logic [2:0] S_BOOT     = 3'd1;
    localparam logic [2:0] S_RUNNING  = 3'd2;
    localparam logic [2:0] S_SHUTDOWN = 3'd3;
    localparam logic [2:0] S_HALTED   = 3'd4;
    localparam logic [2:0] S_LOCKOUT  = 3'd5;

    // Reason latched on entry to SHUTDOWN; decides where SHUTDOWN exits to.
    localparam logic [1:0] CAUSE_CLEAN = 2'd0;
    localparam logic [1:0] CAUSE_PWR   = 2'd1;
    localparam logic [1:0] CAUSE_FAULT = 2'd2;

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_W-1:0]   PRE_LAST     = PRE_W'(TICK_DIV - 1);
    localparam logic [TIMER_W-1:0] STARTUP_T    = TIMER_W'(STARTUP_TICKS);
    localparam logic [TIMER_W-1:0] BOOT_GRACE_T = TIMER_W'(BOOT_GRACE_TICKS);
    localparam logic [TIMER_W-1:0] HB_TIMEOUT_T = TIMER_W'(HB_TIMEOUT_TICKS);
    localparam logic [TIMER_W-1:0] OFF_T        = TIMER_W'(OFF_TICKS);
    localparam logic [TIMER_W-1:0] DEBOUNCE_T   = TIMER_W'(DEBOUNCE_TICKS);
    localparam logic [TIMER_W-1:0] STABLE_T     = TIMER_W'(STABLE_TICKS);
    localparam logic [1:0]         MAX_RC       = 2'(MAX_RESTARTS);

    // -----------------------------------------------------------------------
    // Tick prescaler: counts 0..TICK_DIV-1, tick is high while at TICK_DIV-1
    // -----------------------------------------------------------------------
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == PRE_LAST);

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous board/CPU inputs
    // -----------------------------------------------------------------------
    logic [1:0] pg_sync;
    logic [1:0] hb_sync;
    logic [1:0] req_sync;
    logic       hb_prev;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            pg_sync  <= '0;
            hb_sync  <= '0;
            req_sync <= '0;
            hb_prev  <= 1'b0;
        end else begin
            pg_sync  <= {pg_sync[0], power_good};
            hb_sync  <= {hb_sync[0], cpu_heartbeat};
            req_sync <= {req_sync[0], cpu_shutdown_req};
            hb_prev  <= hb_sync[1];
        end
    end

    logic pg_s;
    logic req_s;
    logic hb_edge;

    assign pg_s    = pg_sync[1];
    assign req_s   = req_sync[1];
    // Either heartbeat edge counts as a sign of life.
    assign hb_edge = hb_sync[1] ^ hb_prev;

    // -----------------------------------------------------------------------
    // Timers and FSM registers
    // -----------------------------------------------------------------------
    logic [TIMER_W-1:0] state_timer;
    logic [TIMER_W-1:0] hb_timer;
    logic [TIMER_W-1:0] deb_cnt;
    logic [1:0]         cause;
    logic               lock_pend;   // this fault exhausts the restart budget

    logic               cpu_on;      // BOOT or RUNNING: CPU powered
    logic               req_ok;

    assign cpu_on = (state == S_BOOT) || (state == S_RUNNING);
    // deb_cnt saturates at DEBOUNCE_TICKS and clears as soon as the request
    // drops, so reaching the limit means that many consecutive ticks high.
    assign req_ok = (deb_cnt >= DEBOUNCE_T);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic [2:0] state_nxt;
    logic [1:0] cause_nxt;
    logic       lock_pend_nxt;
    logic       fault_nxt;
    logic [1:0] rc_nxt;
    logic       timeout;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt     = state;
        cause_nxt     = cause;
        lock_pend_nxt = lock_pend;
        fault_nxt     = fault;
        rc_nxt        = restart_count;
        timeout       = (state == S_BOOT) ? (state_timer == BOOT_GRACE_T)
                                          : (hb_timer == HB_TIMEOUT_T);

        case (state)
            S_STARTUP: begin
                // Timer is held at 0 while power is bad, so this only fires
                // after STARTUP_TICKS of good power.
                if (pg_s && (state_timer == STARTUP_T)) begin
                    state_nxt = S_BOOT;
                end
            end

            S_BOOT, S_RUNNING: begin
                if (!pg_s) begin
                    state_nxt = S_SHUTDOWN;
                    cause_nxt = CAUSE_PWR;
                end else if (req_ok) begin
                    state_nxt = S_SHUTDOWN;
                    cause_nxt = CAUSE_CLEAN;
                end else if (timeout) begin
                    state_nxt = S_SHUTDOWN;
                    cause_nxt = CAUSE_FAULT;
                    fault_nxt = 1'b1;
                    // The count before this fault is the number of restarts
                    // already taken; once that reaches the budget, lock out.
                    lock_pend_nxt = (restart_count >= MAX_RC);
                    rc_nxt        = (restart_count == 2'd3) ? 2'd3
                                                            : restart_count + 2'd1;
                end else if ((state == S_BOOT) && hb_edge) begin
                    state_nxt = S_RUNNING;
                    fault_nxt = 1'b0;
                end else if ((state == S_RUNNING) && (state_timer == STABLE_T)) begin
                    // Long enough without trouble: the fault streak is over.
                    rc_nxt = 2'd0;
                end
            end

            S_SHUTDOWN: begin
                // Power loss here is ignored: the sequencer still needs its
                // full off time before any re-enable.
                if (state_timer == OFF_T) begin
                    case (cause)
                        CAUSE_CLEAN: begin
                            state_nxt = S_HALTED;
                            rc_nxt    = 2'd0;
                        end
                        CAUSE_FAULT: begin
                            state_nxt = lock_pend ? S_LOCKOUT : S_STARTUP;
                        end
                        default: begin
                            state_nxt = S_STARTUP;
                        end
                    endcase
                end
            end

            S_HALTED: begin
                // Leave only after power_good has been seen low on a tick.
                if (tick && !pg_s) begin
                    state_nxt = S_STARTUP;
                end
            end

            S_LOCKOUT: begin
                if (tick && !pg_s) begin
                    state_nxt = S_STARTUP;
                    rc_nxt    = 2'd0;
                end
            end

            default: begin
                state_nxt = S_STARTUP;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, timers and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state         <= S_STARTUP;
            cause         <= CAUSE_CLEAN;
            lock_pend     <= 1'b0;
            state_timer   <= '0;
            hb_timer      <= '0;
            deb_cnt       <= '0;
            fault         <= 1'b0;
            restart_count <= 2'd0;
            enable        <= 1'b0;
            lockout       <= 1'b0;
        end else begin
            state         <= state_nxt;
            cause         <= cause_nxt;
            lock_pend     <= lock_pend_nxt;
            fault         <= fault_nxt;
            restart_count <= rc_nxt;

            // Enable and lockout follow the state one cycle later.
            enable  <= cpu_on;
            lockout <= (state == S_LOCKOUT);

            // State timer: restarts on every state change, saturates.
            if (state_nxt != state) begin
                state_timer <= '0;
            end else if ((state == S_STARTUP) && !pg_s) begin
                state_timer <= '0;
            end else if (tick && (state_timer != '1)) begin
                state_timer <= state_timer + 1'b1;
            end

            // Heartbeat watchdog: only meaningful in RUNNING; any heartbeat
            // edge restarts it regardless of tick phase.
            if ((state != S_RUNNING) || hb_edge) begin
                hb_timer <= '0;
            end else if (tick && (hb_timer != '1)) begin
                hb_timer <= hb_timer + 1'b1;
            end

            // Shutdown-request debounce, live only while the CPU is powered.
            if (!cpu_on || !req_s) begin
                deb_cnt <= '0;
            end else if (tick && (deb_cnt < DEBOUNCE_T)) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exynos4412_supervisor.sv
// ---------------------------------------------------------------------------
// tb_exynos4412_supervisor
//
// Self-checking bench for exynos4412_supervisor with short timing parameters.
// Stimulus pushes the expected sequence of state entries (with the outputs
// expected one cycle after each entry) into a queue; a monitor pops one entry
// per observed state change and compares. Timing windows and hold-off
// behaviour are checked directly in the stimulus.
// ---------------------------------------------------------------------------
module tb_exynos4412_supervisor;

    localparam int unsigned TICK_DIV         = 4;
    localparam int unsigned TIMER_W          = 20;
    localparam int unsigned STARTUP_TICKS    = 3;
    localparam int unsigned BOOT_GRACE_TICKS = 20;
    localparam int unsigned HB_TIMEOUT_TICKS = 5;
    localparam int unsigned OFF_TICKS        = 4;
    localparam int unsigned DEBOUNCE_TICKS   = 2;
    localparam int unsigned STABLE_TICKS     = 10;
    localparam int unsigned MAX_RESTARTS     = 2;

    localparam logic [2:0] S_STARTUP  = 3'd0;
    localparam logic [2:0] S_BOOT     = 3'd1;
    localparam logic [2:0] S_RUNNING  = 3'd2;
    localparam logic [2:0] S_SHUTDOWN = 3'd3;
    localparam logic [2:0] S_HALTED   = 3'd4;
    localparam logic [2:0] S_LOCKOUT  = 3'd5;

    logic       sysclk           = 1'b0;
    logic       reset            = 1'b0;
    logic       power_good       = 1'b0;
    logic       cpu_heartbeat    = 1'b0;
    logic       cpu_shutdown_req = 1'b0;
    logic       enable;
    logic       fault;
    logic       lockout;
    logic [1:0] restart_count;
    logic [2:0] state;

    bit hb_run = 1'b0;

    exynos4412_supervisor #(
        .TICK_DIV         (TICK_DIV),
        .TIMER_W          (TIMER_W),
        .STARTUP_TICKS    (STARTUP_TICKS),
        .BOOT_GRACE_TICKS (BOOT_GRACE_TICKS),
        .HB_TIMEOUT_TICKS (HB_TIMEOUT_TICKS),
        .OFF_TICKS        (OFF_TICKS),
        .DEBOUNCE_TICKS   (DEBOUNCE_TICKS),
        .STABLE_TICKS     (STABLE_TICKS),
        .MAX_RESTARTS     (MAX_RESTARTS)
    ) dut (
        .sysclk           (sysclk),
        .reset            (reset),
        .power_good       (power_good),
        .cpu_heartbeat    (cpu_heartbeat),
        .cpu_shutdown_req (cpu_shutdown_req),
        .enable           (enable),
        .fault            (fault),
        .lockout          (lockout),
        .restart_count    (restart_count),
        .state            (state)
    );

    always #5 sysclk = ~sysclk;

    // Heartbeat source: toggles every 2 ticks while hb_run is set.
    initial begin
        forever begin
            repeat (2 * TICK_DIV) @(negedge sysclk);
            if (hb_run) cpu_heartbeat = ~cpu_heartbeat;
        end
    end

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    typedef struct packed {
        logic [2:0] st;
        logic       en;
        logic       flt;
        logic       lck;
        logic [1:0] rc;
    } exp_t;

    exp_t exp_q[$];

    task automatic expect_entry(input logic [2:0] st, input logic en, input logic flt,
                                input logic lck, input logic [1:0] rc);
        exp_t e;
        e.st  = st;
        e.en  = en;
        e.flt = flt;
        e.lck = lck;
        e.rc  = rc;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: state is compared on the cycle it changes, the
    // registered outputs one cycle later.
    logic [2:0] prev_state = 3'd0;
    bit         pend       = 1'b0;
    exp_t       pend_e;

    always @(negedge sysclk) begin
        if (pend) begin
            check("sb_enable",        enable,        pend_e.en);
            check("sb_fault",         fault,         pend_e.flt);
            check("sb_lockout",       lockout,       pend_e.lck);
            check("sb_restart_count", restart_count, pend_e.rc);
            pend = 1'b0;
        end
        if (state !== prev_state) begin
            prev_state = state;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_state_change", exp_q.size(), 1);
            end else begin
                pend_e = exp_q.pop_front();
                check("sb_state", state, pend_e.st);
                pend = 1'b1;
            end
        end
    end

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag,
                              output int cyc);
        cyc = 0;
        while ((state !== s) && (cyc < budget)) begin
            @(negedge sysclk);
            cyc++;
        end
        check(tag, state, s);
    endtask

    task automatic wait_enable(input logic v, input int budget, input string tag,
                               output int cyc);
        cyc = 0;
        while ((enable !== v) && (cyc < budget)) begin
            @(negedge sysclk);
            cyc++;
        end
        check(tag, enable, v);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int cyc;

        #1 reset = 1'b1;
        power_good = 1'b1;
        repeat (3) @(negedge sysclk);
        check("reset_state",   state,         S_STARTUP);
        check("reset_enable",  enable,        1'b0);
        check("reset_fault",   fault,         1'b0);
        check("reset_lockout", lockout,       1'b0);
        check("reset_rc",      restart_count, 2'd0);

        // Power-up: STARTUP_TICKS of good power, then enable.
        expect_entry(S_BOOT, 1'b1, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        wait_enable(1'b1, 100, "startup_enable_rise", cyc);
        check("startup_latency_window", (cyc >= 12) && (cyc <= 18), 1'b1);
        check("startup_in_boot", state, S_BOOT);

        // Heartbeat every 2 ticks -> RUNNING, enable held.
        expect_entry(S_RUNNING, 1'b1, 1'b0, 1'b0, 2'd0);
        hb_run = 1'b1;
        wait_state(S_RUNNING, 40, "boot_to_running", cyc);
        for (int i = 0; i < 12; i++) begin
            repeat (TICK_DIV) @(negedge sysclk);
            check("running_enable_held", enable, 1'b1);
        end
        check("running_rc_zero", restart_count, 2'd0);

        // Heartbeat stops -> watchdog fault, restart after OFF+STARTUP.
        expect_entry(S_SHUTDOWN, 1'b0, 1'b1, 1'b0, 2'd1);
        expect_entry(S_STARTUP,  1'b0, 1'b1, 1'b0, 2'd1);
        expect_entry(S_BOOT,     1'b1, 1'b1, 1'b0, 2'd1);
        @(cpu_heartbeat);
        hb_run = 1'b0;
        wait_enable(1'b0, 60, "watchdog_enable_fall", cyc);
        check("watchdog_latency_window", (cyc >= 19) && (cyc <= 27), 1'b1);
        check("watchdog_fault", fault, 1'b1);
        check("watchdog_rc", restart_count, 2'd1);
        wait_enable(1'b1, 60, "watchdog_reenable", cyc);
        check("off_plus_startup_window", (cyc >= 24) && (cyc <= 31), 1'b1);

        // Back to RUNNING; restart_count clears after STABLE_TICKS.
        expect_entry(S_RUNNING, 1'b1, 1'b0, 1'b0, 2'd1);
        hb_run = 1'b1;
        wait_state(S_RUNNING, 20, "restart_to_running", cyc);
        repeat (16) @(negedge sysclk);
        check("rc_before_stable", restart_count, 2'd1);
        repeat (40) @(negedge sysclk);
        check("rc_after_stable", restart_count, 2'd0);

        // Shutdown request for one tick: ignored.
        cpu_shutdown_req = 1'b1;
        repeat (TICK_DIV) @(negedge sysclk);
        cpu_shutdown_req = 1'b0;
        repeat (24) @(negedge sysclk);
        check("short_req_ignored_state",  state,  S_RUNNING);
        check("short_req_ignored_enable", enable, 1'b1);

        // Shutdown request for two ticks: clean shutdown to HALTED.
        expect_entry(S_SHUTDOWN, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_entry(S_HALTED,   1'b0, 1'b0, 1'b0, 2'd0);
        cpu_shutdown_req = 1'b1;
        repeat (2 * TICK_DIV) @(negedge sysclk);
        cpu_shutdown_req = 1'b0;
        wait_state(S_HALTED, 60, "clean_to_halted", cyc);
        repeat (60) @(negedge sysclk);
        check("halted_stays",        state,  S_HALTED);
        check("halted_enable_low",   enable, 1'b0);

        // Power cycle releases HALTED.
        expect_entry(S_STARTUP, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_entry(S_BOOT,    1'b1, 1'b0, 1'b0, 2'd0);
        expect_entry(S_RUNNING, 1'b1, 1'b0, 1'b0, 2'd0);
        power_good = 1'b0;
        repeat (2 * TICK_DIV) @(negedge sysclk);
        power_good = 1'b1;
        wait_state(S_RUNNING, 100, "halted_power_cycle", cyc);

        // Power loss together with a shutdown request: power cause wins.
        expect_entry(S_SHUTDOWN, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_entry(S_STARTUP,  1'b0, 1'b0, 1'b0, 2'd0);
        power_good       = 1'b0;
        cpu_shutdown_req = 1'b1;
        wait_state(S_SHUTDOWN, 10, "pwr_loss_shutdown", cyc);
        wait_state(S_STARTUP, 40, "pwr_loss_to_startup", cyc);
        check("pwr_loss_full_off_time", cyc >= 12, 1'b1);
        cpu_shutdown_req = 1'b0;
        repeat (20) @(negedge sysclk);
        check("startup_held_without_power", state, S_STARTUP);
        expect_entry(S_BOOT,    1'b1, 1'b0, 1'b0, 2'd0);
        expect_entry(S_RUNNING, 1'b1, 1'b0, 1'b0, 2'd0);
        power_good = 1'b1;
        wait_state(S_RUNNING, 100, "power_return_running", cyc);

        // Reset while RUNNING drops enable without waiting for a clock.
        expect_entry(S_STARTUP, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge sysclk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_enable", enable, 1'b0);
        check("async_reset_state",  state,  S_STARTUP);
        hb_run = 1'b0;
        repeat (3) @(negedge sysclk);

        // No heartbeat ever: two grace-fault restarts, then LOCKOUT.
        expect_entry(S_BOOT,     1'b1, 1'b0, 1'b0, 2'd0);
        expect_entry(S_SHUTDOWN, 1'b0, 1'b1, 1'b0, 2'd1);
        expect_entry(S_STARTUP,  1'b0, 1'b1, 1'b0, 2'd1);
        expect_entry(S_BOOT,     1'b1, 1'b1, 1'b0, 2'd1);
        expect_entry(S_SHUTDOWN, 1'b0, 1'b1, 1'b0, 2'd2);
        expect_entry(S_STARTUP,  1'b0, 1'b1, 1'b0, 2'd2);
        expect_entry(S_BOOT,     1'b1, 1'b1, 1'b0, 2'd2);
        expect_entry(S_SHUTDOWN, 1'b0, 1'b1, 1'b0, 2'd3);
        expect_entry(S_LOCKOUT,  1'b0, 1'b1, 1'b1, 2'd3);
        reset = 1'b0;
        cyc = 0;
        while ((lockout !== 1'b1) && (cyc < 1500)) begin
            @(negedge sysclk);
            cyc++;
        end
        check("lockout_reached", lockout, 1'b1);
        repeat (40) @(negedge sysclk);
        check("lockout_stays",      state,  S_LOCKOUT);
        check("lockout_enable_low", enable, 1'b0);

        // Power cycle releases LOCKOUT and clears restart_count; the fault
        // flag stays set until the CPU reaches RUNNING again.
        expect_entry(S_STARTUP, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_entry(S_BOOT,    1'b1, 1'b1, 1'b0, 2'd0);
        power_good = 1'b0;
        repeat (2 * TICK_DIV) @(negedge sysclk);
        power_good = 1'b1;
        wait_enable(1'b1, 100, "lockout_release_enable", cyc);
        check("lockout_release_rc",      restart_count, 2'd0);
        check("lockout_release_lockout", lockout,       1'b0);

        repeat (4) @(negedge sysclk);
        check("sb_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed so far",
                 n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
